div_16b_seq: RTL and testbench

Iterative 16-bit unsigned restoring divider for the datapath's multi-cycle arithmetic.
- Inverse of the single-cycle 16-bit lookahead adder: subtracts the divisor once per cycle and retires one quotient bit per cycle.
- Sits beside the ALU as a start/done coprocessor.
- The pipeline stalls on `busy` and captures the result on `done`.

---
 rtl/div_16b_seq.sv | 72 +++++++
 tb/tb_div_16b_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_16b_seq.sv
// div_16b_seq: iterative unsigned restoring divider with a start/done handshake.
// Retires one quotient bit per cycle; a zero divisor finishes in a single cycle.
module div_16b_seq #(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] q, r, d, q_nx, r_nx, diff;
  logic [N:0] t;
  logic [CNT_W-1:0] cnt;
  logic accept, zero, last, no_borrow;
  assign accept    = start && state != RUN;
  assign zero      = divisor == '0;
  assign last      = cnt == CNT_W'(N - 1);
  assign busy      = state == RUN;
  assign done      = state == DONE;
  // The remainder never reaches 2^N, so its top bit is not stored and the
  // difference fits in N bits whenever there is no borrow.
  assign t         = {r, q[N-1]};
  assign no_borrow = t >= {1'b0, d};
  assign diff      = t[N-1:0] - d;
  assign r_nx      = no_borrow ? diff : t[N-1:0];
  assign q_nx      = {q[N-2:0], no_borrow};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == RUN) state_nx = last ? DONE : RUN;
    else state_nx = accept ? (zero ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (accept) begin
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
      cnt <= '0;
    end else if (state == RUN) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        quotient    <= q_nx;
        remainder   <= r_nx;
        div_by_zero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_div_16b_seq.sv
// tb_div_16b_seq: table vectors, hand-written handshake corner cases and random
// operands checked against plain integer division.
module tb_div_16b_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int vectors = 0, miscompares = 0;

  div_16b_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clk); #1 n++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic check_res(input string tag, input int eq, input int er, input int ez);
    chk($sformatf("%s done", tag), done, 1);
    chk($sformatf("%s quotient", tag), quotient, eq);
    chk($sformatf("%s remainder", tag), remainder, er);
    chk($sformatf("%s dbz", tag), div_by_zero, ez);
    chk($sformatf("%s busy_at_done", tag), busy, 0);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez);
    int n, nb;
    launch(a, b);
    wait_done(n, nb);
    chk($sformatf("%s latency", tag), n, b == 0 ? 0 : 16);
    chk($sformatf("%s busy_cycles", tag), nb, b == 0 ? 0 : 16);
    check_res(tag, eq, er, ez);
    @(posedge clk); #1;
    chk($sformatf("%s done_pulse", tag), done, 0);
  endtask

  initial begin
    vec_t tbl[$];
    int n, nb;
    logic [15:0] a, b;
    tbl.push_back('{16'd100, 16'd7, 16'd14, 16'd2, 1'b0});
    tbl.push_back('{16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0});
    tbl.push_back('{16'd5, 16'd9, 16'd0, 16'd5, 1'b0});
    tbl.push_back('{16'd0, 16'd3, 16'd0, 16'd0, 1'b0});
    tbl.push_back('{16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1});
    tbl.push_back('{16'd40000, 16'd123, 16'd325, 16'd25, 1'b0});
    tbl.push_back('{16'd1000, 16'd3, 16'd333, 16'd1, 1'b0});

    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1;

    foreach (tbl[i]) do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

    // start pulsed during RUN must be ignored
    launch(16'd1000, 16'd3);
    n = 0;
    repeat (8) begin @(posedge clk); #1 n++; end
    dividend = 16'd50;
    divisor = 16'd5;
    start = 1;
    @(posedge clk); #1 start = 0;
    n++;
    while (!done && n < 40) begin @(posedge clk); #1 n++; end
    chk("ignored_start latency", n, 16);
    check_res("ignored_start", 333, 1, 0);

    // back-to-back: start held in the DONE cycle
    dividend = 16'd40000;
    divisor = 16'd123;
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("b2b busy", busy, 1);
    chk("b2b done_falls", done, 0);
    repeat (8) @(posedge clk);
    #1 chk("b2b hold_q", quotient, 333);
    chk("b2b hold_r", remainder, 1);
    wait_done(n, nb);
    chk("b2b latency", n + 8, 16);
    check_res("b2b", 325, 25, 0);
    @(posedge clk); #1;

    // divide-by-zero back-to-back keeps done high
    launch(16'd1234, 16'd0);
    check_res("dz1", 16'hFFFF, 1234, 1);
    dividend = 16'd7;
    start = 1;
    @(posedge clk); #1 start = 0;
    check_res("dz2", 16'hFFFF, 7, 1);
    @(posedge clk); #1;
    chk("dz2 done_pulse", done, 0);

    // asynchronous reset mid-RUN
    launch(16'd1000, 16'd3);
    repeat (5) @(posedge clk);
    #4 rst_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst quotient", quotient, 0);
    chk("arst remainder", remainder, 0);
    chk("arst dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1;
    nb = 0;
    repeat (20) begin @(posedge clk); #1 if (done || busy) nb++; end
    chk("arst no_done", nb, 0);
    do_op("post_reset", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0);

    // random operands against integer division
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = (i % 6 == 5) ? 16'd0 : (i % 3 == 0 ? 16'($urandom_range(1, 300)) : 16'($urandom));
      if (b == 0) do_op($sformatf("rnd%0d", i), a, b, 16'hFFFF, a, 1'b1);
      else do_op($sformatf("rnd%0d", i), a, b, 16'(a / b), 16'(a % b), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
